// File: rtl/vram_arbiter_if.sv
// Purpose : bundle of the two requester handshakes and the BRAM port of vram_arbiter.
// Latency : none, wires only.
// Backpressure: req/gnt handshake. A requester holds req and its qualifiers until gnt.
// Ports   : disp_* display read channel, cpu_* CPU read/write channel, mem_* BRAM port.
// Modports: slave is the arbiter side. master is the requester/BRAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic                  disp_req;
  logic [ADDR_W-1:0]     disp_addr;
  logic                  disp_gnt;
  logic                  disp_rvalid;
  logic [DATA_W-1:0]     disp_rdata;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [DATA_W/8-1:0]   cpu_be;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [DATA_W-1:0]     cpu_rdata;

  logic                  mem_en;
  logic [DATA_W/8-1:0]   mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  disp_req, disp_addr,
    output disp_gnt, disp_rvalid, disp_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_gnt, disp_rvalid, disp_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Purpose : shares one single-port VRAM between the display fetch (read) and the CPU bridge (read/write).
// Latency : gnt is combinational in the request cycle. rvalid follows MEM_LAT cycles after the granting edge.
// Backpressure: display wins a collision. The CPU is forced through after MAX_WAIT refused cycles.
// Ports   : Clk, reset_rtl_0 (async, active low). bus (vram_arbiter_if.slave) carries both
//           requester channels and the BRAM port.
// Option  : VRAM_ARB_STATS_EN adds stat_clr, stat_cpu_stalls and stat_forced counters.
module vram_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic          Clk,
  input  logic          reset_rtl_0,
`ifdef VRAM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_cpu_stalls,
  output logic [15:0]   stat_forced,
`endif
  vram_arbiter_if.slave bus
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic [7:0]        wait_cnt;
  logic [1:0]        tag_q [MEM_LAT];   // {is_disp_read, is_cpu_read}
  logic              forced;
  logic              disp_win;
  logic              cpu_win;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [BE_W-1:0]   we_sel;

  // Arbitration. The winners are ungated by reset so the flops never see reset in their data path.
  always_comb begin
    forced   = bus.disp_req && bus.cpu_req && (wait_cnt == WAIT_LIM);
    disp_win = bus.disp_req && !forced;
    cpu_win  = bus.cpu_req && !disp_win;
  end

  // Grants are one-hot, so the select order here does not matter.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = '0;
    if (cpu_win) begin
      addr_sel  = bus.cpu_addr;
      wdata_sel = bus.cpu_wdata;
      if (bus.cpu_we) begin
        we_sel = bus.cpu_be;
      end
    end else if (disp_win) begin
      addr_sel = bus.disp_addr;
    end
  end

  // All strobes are held low while reset is asserted, even though req may be high.
  assign bus.disp_gnt    = reset_rtl_0 & disp_win;
  assign bus.cpu_gnt     = reset_rtl_0 & cpu_win;
  assign bus.mem_en      = reset_rtl_0 & (disp_win | cpu_win);
  assign bus.mem_we      = reset_rtl_0 ? we_sel : '0;
  assign bus.mem_addr    = addr_sel;
  assign bus.mem_wdata   = wdata_sel;

  // The CPU wait counter counts refused cycles. It saturates at MAX_WAIT, where the next collision goes to the CPU.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      wait_cnt <= '0;
    end else if (!bus.cpu_req || cpu_win) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIM) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // The return tag pipeline matches the BRAM read latency. A write injects 00, so it never produces rvalid.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_q[i] <= 2'b00;
      end
    end else begin
      tag_q[0] <= {disp_win, cpu_win && !bus.cpu_we};
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign bus.disp_rvalid = reset_rtl_0 & tag_q[MEM_LAT-1][1];
  assign bus.cpu_rvalid  = reset_rtl_0 & tag_q[MEM_LAT-1][0];
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata   = bus.mem_rdata;

`ifdef VRAM_ARB_STATS_EN
  // Clear has priority over a same-cycle increment.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      stat_cpu_stalls <= '0;
      stat_forced     <= '0;
    end else if (stat_clr) begin
      stat_cpu_stalls <= '0;
      stat_forced     <= '0;
    end else begin
      if (bus.cpu_req && !cpu_win && stat_cpu_stalls != 16'hFFFF) begin
        stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
      end
      if (forced && stat_forced != 16'hFFFF) begin
        stat_forced <= stat_forced + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Purpose : directed bench for vram_arbiter, with two instances (MEM_LAT=1/MAX_WAIT=8 and MEM_LAT=3/MAX_WAIT=1).
// Latency : inputs change 1 ns after the rising edge. Outputs are sampled 1-2 ns after the edge.
// Backpressure: requesters hold req until gnt. Assertions flag a dropped request.
module tb_vram_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic reset_rtl_0;
  logic boot;
  logic stat_clr;
  int   checks   = 0;
  int   failures = 0;

  vram_arbiter_if #(.ADDR_W(11), .DATA_W(32)) if0 ();
  vram_arbiter_if #(.ADDR_W(11), .DATA_W(32)) if1 ();

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] st0_stalls, st0_forced, st1_stalls, st1_forced;
`endif

  vram_arbiter #(.ADDR_W(11), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(8)) u0 (
    .Clk             (Clk),
    .reset_rtl_0     (reset_rtl_0),
`ifdef VRAM_ARB_STATS_EN
    .stat_clr        (stat_clr),
    .stat_cpu_stalls (st0_stalls),
    .stat_forced     (st0_forced),
`endif
    .bus             (if0)
  );

  vram_arbiter #(.ADDR_W(11), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(1)) u1 (
    .Clk             (Clk),
    .reset_rtl_0     (reset_rtl_0),
`ifdef VRAM_ARB_STATS_EN
    .stat_clr        (stat_clr),
    .stat_cpu_stalls (st1_stalls),
    .stat_forced     (st1_forced),
`endif
    .bus             (if1)
  );

  function automatic logic [31:0] init_word(input int a);
    return 32'hA500_0000 + 32'(a);
  endfunction

  // Read-first BRAM models: 1-cycle for u0, 3-cycle for u1.
  logic [31:0] mem0 [2048];
  logic [31:0] mem1 [2048];
  logic [31:0] rd0, rd1a, rd1b, rd1c;

  always @(posedge Clk) begin
    if (boot) begin
      for (int i = 0; i < 2048; i++) mem0[i] <= init_word(i);
    end else if (if0.mem_en) begin
      rd0 <= mem0[if0.mem_addr];
      for (int b = 0; b < 4; b++)
        if (if0.mem_we[b]) mem0[if0.mem_addr][8*b +: 8] <= if0.mem_wdata[8*b +: 8];
    end
  end

  always @(posedge Clk) begin
    if (boot) begin
      for (int i = 0; i < 2048; i++) mem1[i] <= init_word(i);
    end else if (if1.mem_en) begin
      rd1a <= mem1[if1.mem_addr];
      for (int b = 0; b < 4; b++)
        if (if1.mem_we[b]) mem1[if1.mem_addr][8*b +: 8] <= if1.mem_wdata[8*b +: 8];
    end
    rd1b <= rd1a;
    rd1c <= rd1b;
  end

  assign if0.mem_rdata = rd0;
  assign if1.mem_rdata = rd1c;

  // A request may not be withdrawn before it is granted.
  a_hold_d0: assert property (@(posedge Clk) disable iff (!reset_rtl_0) (if0.disp_req && !if0.disp_gnt) |=> if0.disp_req);
  a_hold_c0: assert property (@(posedge Clk) disable iff (!reset_rtl_0) (if0.cpu_req && !if0.cpu_gnt) |=> if0.cpu_req);
  a_hold_d1: assert property (@(posedge Clk) disable iff (!reset_rtl_0) (if1.disp_req && !if1.disp_gnt) |=> if1.disp_req);
  a_hold_c1: assert property (@(posedge Clk) disable iff (!reset_rtl_0) (if1.cpu_req && !if1.cpu_gnt) |=> if1.cpu_req);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_all();
    if0.disp_req = 1'b0; if0.disp_addr = '0; if0.cpu_req = 1'b0; if0.cpu_we = 1'b0;
    if0.cpu_addr = '0;   if0.cpu_wdata = '0; if0.cpu_be = '0;
    if1.disp_req = 1'b0; if1.disp_addr = '0; if1.cpu_req = 1'b0; if1.cpu_we = 1'b0;
    if1.cpu_addr = '0;   if1.cpu_wdata = '0; if1.cpu_be = '0;
  endtask

  // Both channels are held high on u0 until the CPU is forced through. The display is held one more cycle.
  task automatic forced_run(output int n_before, output int cpu_at, output logic d10,
                            output logic rv_ok, output int dual);
    logic pend, got;
    pend = 1'b1; n_before = 0; cpu_at = 0; d10 = 1'b0; rv_ok = 1'b0; dual = 0;
    if0.cpu_we = 1'b0; if0.cpu_addr = 11'h020; if0.disp_addr = 11'h100;
    for (int c = 1; c <= 10; c++) begin
      if0.disp_req = 1'b1;
      if0.cpu_req  = pend;
      #1;
      if (if0.disp_gnt && if0.cpu_gnt) dual++;
      if (if0.disp_gnt && pend) n_before++;
      if (c == 10) d10 = if0.disp_gnt;
      got = if0.cpu_gnt;
      if (if0.cpu_gnt) begin cpu_at = c; pend = 1'b0; end
      step();
      if (got) rv_ok = if0.cpu_rvalid && !if0.disp_rvalid && (if0.cpu_rdata == init_word('h20));
    end
    if0.disp_req = 1'b0;
  endtask

  initial begin
    int gn, rv, dok, crv, nb, ca, dual, bad, rcpu;
    logic d10, rvok;
    logic [15:0] dg, cg, dr, cr;
    logic [7:0]  drv;

    reset_rtl_0 = 1'b0; boot = 1'b1; stat_clr = 1'b0;
    idle_all();
    if0.disp_req = 1'b1; if0.cpu_req = 1'b1; if0.cpu_we = 1'b1; if0.cpu_be = 4'hF;
    if1.disp_req = 1'b1; if1.cpu_req = 1'b1;
    step(); step();
    // Outputs are held low while in reset, even with requests pending.
    check("rst_disp_gnt",  if0.disp_gnt, 0);
    check("rst_cpu_gnt",   if0.cpu_gnt, 0);
    check("rst_mem_en",    if0.mem_en, 0);
    check("rst_mem_we",    if0.mem_we, 0);
    check("rst_rvalid",    {if0.disp_rvalid, if0.cpu_rvalid, if1.disp_rvalid, if1.cpu_rvalid}, 0);
    idle_all();
    boot = 1'b0;
    step();
    reset_rtl_0 = 1'b1;

    // CPU write, then a read-back.
    if0.cpu_req = 1'b1; if0.cpu_we = 1'b1; if0.cpu_addr = 11'h010;
    if0.cpu_wdata = 32'hDEAD_BEEF; if0.cpu_be = 4'hF;
    #1;
    check("wr_gnt",       if0.cpu_gnt, 1);
    check("wr_mem_we",    if0.mem_we, 4'hF);
    check("wr_mem_addr",  if0.mem_addr, 11'h010);
    check("wr_mem_wdata", if0.mem_wdata, 32'hDEAD_BEEF);
    step();
    if0.cpu_we = 1'b0;
    #1;
    check("rd_gnt",       if0.cpu_gnt, 1);
    check("wr_no_rvalid", if0.cpu_rvalid, 0);
    check("rd_mem_we",    if0.mem_we, 0);
    step();
    if0.cpu_req = 1'b0;
    check("rd_rvalid",    if0.cpu_rvalid, 1);
    check("rd_data",      if0.cpu_rdata, 32'hDEAD_BEEF);
    check("rd_no_disp",   if0.disp_rvalid, 0);
    step();
    check("rd_pulse_end", if0.cpu_rvalid, 0);
    check("idle_mem",     {if0.mem_en, if0.mem_addr}, 0);

    // Display streaming of addresses 0..15.
    gn = 0; rv = 0; dok = 0; crv = 0;
    for (int k = 0; k <= 16; k++) begin
      if (if0.disp_rvalid) begin
        rv++;
        if (if0.disp_rdata == init_word(k - 1)) dok++;
      end
      if (if0.cpu_rvalid) crv++;
      if (k < 16) begin if0.disp_req = 1'b1; if0.disp_addr = 11'(k); end
      else if0.disp_req = 1'b0;
      #1;
      if (if0.disp_gnt) gn++;
      step();
    end
    check("strm_gnt",    gn, 16);
    check("strm_rvalid", rv, 16);
    check("strm_data",   dok, 16);
    check("strm_no_cpu", crv, 0);

    // Forced CPU slot, run twice. The second run only repeats if wait_cnt cleared after the first.
    for (int r = 0; r < 2; r++) begin
      forced_run(nb, ca, d10, rvok, dual);
      check("fw_disp_first", nb, 8);
      check("fw_cpu_cycle",  ca, 9);
      check("fw_disp_after", d10, 1);
      check("fw_cpu_rdata",  rvok, 1);
      check("fw_one_hot",    dual, 0);
    end
    step();
`ifdef VRAM_ARB_STATS_EN
    check("st_stalls", st0_stalls, 16);
    check("st_forced", st0_forced, 2);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("st_clr", {st0_stalls, st0_forced}, 0);
`endif

    // u1: MAX_WAIT=1 alternation with the 3-cycle return pipeline.
    dg = '0; cg = '0; dr = '0; cr = '0; bad = 0;
    for (int c = 1; c <= 14; c++) begin
      if1.disp_req = (c <= 9); if1.cpu_req = (c <= 8);
      if1.disp_addr = 11'd5; if1.cpu_addr = 11'd6; if1.cpu_we = 1'b0;
      #1;
      dg[c] = if1.disp_gnt;    cg[c] = if1.cpu_gnt;
      dr[c] = if1.disp_rvalid; cr[c] = if1.cpu_rvalid;
      if (if1.disp_rvalid && if1.disp_rdata != init_word(5)) bad++;
      if (if1.cpu_rvalid && if1.cpu_rdata != init_word(6)) bad++;
      step();
    end
    check("alt_disp_gnt", dg, 16'h02AA);
    check("alt_cpu_gnt",  cg, 16'h0154);
    check("alt_disp_rv",  dr, 16'h1550);
    check("alt_cpu_rv",   cr, 16'h0AA0);
    check("alt_data",     bad, 0);

    // Reset one cycle after a CPU read grant on u1. That read must never return.
    if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 11'd7;
    #1;
    check("rst_pre_gnt", if1.cpu_gnt, 1);
    step();
    if1.cpu_req = 1'b0;
    reset_rtl_0 = 1'b0;
    if1.disp_req = 1'b1; if1.disp_addr = 11'd3;
    #1;
    check("rst2_gnt",  {if1.disp_gnt, if1.cpu_gnt}, 0);
    check("rst2_mem",  {if1.mem_en, if1.mem_we}, 0);
    rcpu = 0;
    for (int c = 0; c < 2; c++) begin
      if (if1.cpu_rvalid || if1.disp_rvalid) rcpu++;
      step();
    end
    reset_rtl_0 = 1'b1;
    #1;
    check("post_rst_gnt", if1.disp_gnt, 1);
    drv = '0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) if1.disp_req = 1'b0;
      if (if1.cpu_rvalid) rcpu++;
      drv[c] = if1.disp_rvalid;
    end
    check("rst_no_cpu_rv", rcpu, 0);
    check("post_rst_rv",   drv, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
